// File: rtl/hs32_periph_pkg.sv
// Definitions shared by the HS32 memory-mapped peripherals: register word
// offsets of the GPIO block and the encoding of the bus handshake state.
package hs32_periph_pkg;

  localparam int GPIO_OUT  = 0;
  localparam int GPIO_DIR  = 1;
  localparam int GPIO_IN   = 2;
  localparam int GPIO_LED  = 3;
  localparam int GPIO_IEN  = 4;
  localparam int GPIO_PEND = 5;
  localparam int GPIO_EDGE = 6;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/gpio_ctl_if.sv
// HS32 core load/store bus as seen by a peripheral: strobe/direction/address/
// write data from the core, read data and one-cycle acknowledge back.
interface gpio_ctl_if #(
  parameter int AW = 4
);

  logic          stb;
  logic          rw;
  logic [AW-1:0] addr;
  logic [31:0]   dtw;
  logic [31:0]   dtr;
  logic          ack;

  modport master (output stb, rw, addr, dtw, input dtr, ack);
  modport slave  (input stb, rw, addr, dtw, output dtr, ack);

endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop synchroniser for the raw GPIO inputs, a history flop, and a
// per-pin edge detector whose polarity is selected by edge_sel (1=rising).
module gpio_sync_edge #(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pin,
  input  logic [N-1:0] edge_sel,
  output logic [N-1:0] level,
  output logic [N-1:0] hit
);

  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;
  logic [N-1:0] prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= pin;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign hit   = (edge_sel & s2_q & ~prev_q) | (~edge_sel & ~s2_q & prev_q);

endmodule

// File: rtl/gpio_ctl.sv
// Memory-mapped GPIO/LED peripheral: two-state bus handshake, register file,
// read mux, edge-triggered pending bits and a registered level interrupt.
module gpio_ctl
  import hs32_periph_pkg::*;
#(
  parameter int NGPIO = 9,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  gpio_ctl_if.slave        bus,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_oe,
  output logic             ledr_n,
  output logic             ledg_n,
  output logic             irq
);

  // Captured write data must cover both the pin registers and the 2-bit LED field.
  localparam int WW = (NGPIO > 2) ? NGPIO : 2;

  bus_state_t       state_q, state_d;
  logic             rw_q;
  logic [AW-1:0]    addr_q;
  logic [WW-1:0]    wdata_q;

  logic [NGPIO-1:0] out_q, dir_q, ien_q, pend_q, edge_q;
  logic [1:0]       led_q;
  logic             irq_q;

  logic [NGPIO-1:0] in_level, hit, w1c;
  logic             wr_en;
  logic [31:0]      rdata;

  gpio_sync_edge #(.N(NGPIO)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .pin      (gpio_i),
    .edge_sel (edge_q),
    .level    (in_level),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= BUS_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case can leave it holding a value and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUS_IDLE: if (bus.stb) state_d = BUS_ACK;
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // NOTE: pure datapath capture flops carry no reset; they are only consumed
  // in BUS_ACK, which is always preceded by a capture.
  always_ff @(posedge clk) begin
    if (state_q == BUS_IDLE && bus.stb) begin
      rw_q    <= bus.rw;
      addr_q  <= bus.addr;
      wdata_q <= bus.dtw[WW-1:0];
    end
  end

  assign wr_en = (state_q == BUS_ACK) && rw_q;
  assign w1c   = (wr_en && addr_q == AW'(GPIO_PEND)) ? wdata_q[NGPIO-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      dir_q  <= '0;
      led_q  <= '0;
      ien_q  <= '0;
      pend_q <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr_q)
          AW'(GPIO_OUT):  out_q  <= wdata_q[NGPIO-1:0];
          AW'(GPIO_DIR):  dir_q  <= wdata_q[NGPIO-1:0];
          AW'(GPIO_LED):  led_q  <= wdata_q[1:0];
          AW'(GPIO_IEN):  ien_q  <= wdata_q[NGPIO-1:0];
          AW'(GPIO_EDGE): edge_q <= wdata_q[NGPIO-1:0];
          default: ;
        endcase
      end
      // A fresh hit is OR-ed in after the clear so it survives a same-cycle w1c.
      pend_q <= (pend_q & ~w1c) | hit;
      irq_q  <= |(pend_q & ien_q);
    end
  end

  always_comb begin
    rdata = '0;
    case (addr_q)
      AW'(GPIO_OUT):  rdata[NGPIO-1:0] = out_q;
      AW'(GPIO_DIR):  rdata[NGPIO-1:0] = dir_q;
      AW'(GPIO_IN):   rdata[NGPIO-1:0] = in_level;
      AW'(GPIO_LED):  rdata[1:0]       = led_q;
      AW'(GPIO_IEN):  rdata[NGPIO-1:0] = ien_q;
      AW'(GPIO_PEND): rdata[NGPIO-1:0] = pend_q;
      AW'(GPIO_EDGE): rdata[NGPIO-1:0] = edge_q;
      default: ;
    endcase
  end

  assign bus.ack = (state_q == BUS_ACK);
  assign bus.dtr = bus.ack ? rdata : 32'd0;

  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign ledr_n  = ~led_q[1];
  assign ledg_n  = ~led_q[0];
  assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_ctl.sv
// Self-checking bench for gpio_ctl: bus transfers with a read-data scoreboard,
// pin outputs, LEDs, edge interrupts, w1c collision, unmapped and reset cases.
module tb_gpio_ctl;

  localparam int NGPIO = 9;
  localparam int AW    = 4;

  localparam logic [AW-1:0] A_OUT  = 4'd0;
  localparam logic [AW-1:0] A_DIR  = 4'd1;
  localparam logic [AW-1:0] A_IN   = 4'd2;
  localparam logic [AW-1:0] A_LED  = 4'd3;
  localparam logic [AW-1:0] A_IEN  = 4'd4;
  localparam logic [AW-1:0] A_PEND = 4'd5;
  localparam logic [AW-1:0] A_EDGE = 4'd6;

  logic             clk = 1'b0;
  logic             reset;
  logic [NGPIO-1:0] gpio_i;
  logic [NGPIO-1:0] gpio_o;
  logic [NGPIO-1:0] gpio_oe;
  logic             ledr_n;
  logic             ledg_n;
  logic             irq;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  gpio_ctl_if #(.AW(AW)) bus ();

  gpio_ctl #(.NGPIO(NGPIO), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .ledr_n  (ledr_n),
    .ledg_n  (ledg_n),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // One bus transfer; checks ack latency, single-cycle ack and dtr=0 after.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                      output logic [31:0] rd);
    int cyc;
    bit got;
    @(negedge clk);
    bus.stb = 1'b1; bus.rw = wr; bus.addr = a; bus.dtw = d;
    got = 0; cyc = 0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (bus.ack === 1'b1) got = 1;
    end
    rd = bus.dtr;
    bus.stb = 1'b0; bus.rw = 1'b0;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL ack_timeout addr=%0h: got no ack in 8 cycles, expected ack=1", a);
    end else if (cyc != 1) begin
      n_err++;
      $display("FAIL ack_latency addr=%0h: got %0d cycles, expected 1", a, cyc);
    end
    @(negedge clk);
    n_vec++;
    if (bus.ack !== 1'b0 || bus.dtr !== 32'd0) begin
      n_err++;
      $display("FAIL ack_pulse addr=%0h: got ack=%b dtr=%h, expected ack=0 dtr=0",
               a, bus.ack, bus.dtr);
    end
  endtask

  task automatic wr_reg(input logic [AW-1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    xfer(1'b1, a, d, rd);
  endtask

  task automatic rd_reg(input logic [AW-1:0] a, input logic [31:0] expv, input string name);
    logic [31:0] rd, e;
    exp_q.push_back(expv);
    xfer(1'b0, a, 32'd0, rd);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, rd, e);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (gpio_oe !== '0 || gpio_o !== '0) begin
      n_err++;
      $display("FAIL reset_pins: got oe=%h o=%h, expected 0 0", gpio_oe, gpio_o);
    end
    n_vec++;
    if (ledr_n !== 1'b1 || ledg_n !== 1'b1) begin
      n_err++;
      $display("FAIL reset_leds: got r=%b g=%b, expected 1 1", ledr_n, ledg_n);
    end
    n_vec++;
    if (irq !== 1'b0 || bus.ack !== 1'b0 || bus.dtr !== 32'd0) begin
      n_err++;
      $display("FAIL reset_bus: got irq=%b ack=%b dtr=%h, expected 0 0 0", irq, bus.ack, bus.dtr);
    end
  endtask

  task automatic test_out_dir;
    wr_reg(A_DIR, 32'h0000_01FF);
    wr_reg(A_OUT, 32'h0000_00A5);
    n_vec++;
    if (gpio_oe !== 9'h1FF || gpio_o !== 9'h0A5) begin
      n_err++;
      $display("FAIL out_dir_pins: got oe=%h o=%h, expected 1ff 0a5", gpio_oe, gpio_o);
    end
    rd_reg(A_OUT, 32'h0000_00A5, "read_out");
    rd_reg(A_DIR, 32'h0000_01FF, "read_dir");
  endtask

  task automatic test_led_mask;
    wr_reg(A_LED, 32'h0000_0002);
    n_vec++;
    if (ledr_n !== 1'b0 || ledg_n !== 1'b1) begin
      n_err++;
      $display("FAIL led_pins: got r=%b g=%b, expected 0 1", ledr_n, ledg_n);
    end
    rd_reg(A_LED, 32'h0000_0002, "read_led");
    wr_reg(A_OUT, 32'hFFFF_FFFF);
    rd_reg(A_OUT, 32'h0000_01FF, "out_mask");
  endtask

  task automatic test_edge_irq;
    wr_reg(A_EDGE, 32'h1);
    wr_reg(A_IEN, 32'h1);
    @(negedge clk) gpio_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_early: got irq=%b at +3, expected 0", irq);
    end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_rise: got irq=%b at +4, expected 1", irq);
    end
    rd_reg(A_PEND, 32'h1, "pend_rise");
    wr_reg(A_PEND, 32'h1);
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: got irq=%b, expected 0", irq);
    end
    @(negedge clk) gpio_i[0] = 1'b0;
    repeat (6) @(negedge clk);
    rd_reg(A_PEND, 32'h0, "pend_fall_ignored");
  endtask

  task automatic test_w1c_collision;
    @(negedge clk) gpio_i[0] = 1'b1;
    wr_reg(A_PEND, 32'h1);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_before_set: got irq=%b, expected 0", irq);
    end
    rd_reg(A_PEND, 32'h1, "w1c_set_wins");
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_after_set: got irq=%b, expected 1", irq);
    end
    wr_reg(A_PEND, 32'h1);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_clear_lag: got irq=%b, expected 1", irq);
    end
    @(negedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clean_clear: got irq=%b, expected 0", irq);
    end
  endtask

  task automatic test_unmapped;
    rd_reg(4'hF, 32'h0, "unmapped_read");
    wr_reg(4'h7, 32'hFFFF_FFFF);
    rd_reg(A_OUT, 32'h0000_01FF, "unmapped_write_dropped");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.stb = 1'b1; bus.rw = 1'b1; bus.addr = A_OUT; bus.dtw = 32'h0000_0123;
    @(negedge clk);
    n_vec++;
    if (bus.ack !== 1'b1) begin
      n_err++;
      $display("FAIL mid_ack: got ack=%b, expected 1", bus.ack);
    end
    reset = 1'b1;
    bus.stb = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.ack !== 1'b0) begin
      n_err++;
      $display("FAIL mid_ack_drop: got ack=%b, expected 0", bus.ack);
    end
    reset = 1'b0;
    rd_reg(A_OUT, 32'h0, "mid_write_lost");
  endtask

  task automatic test_in;
    wr_reg(A_DIR, 32'h0000_01FF);
    @(negedge clk) gpio_i = 9'h155;
    repeat (3) @(negedge clk);
    rd_reg(A_IN, 32'h0000_0155, "read_in");
  endtask

  initial begin
    reset    = 1'b1;
    gpio_i   = '0;
    bus.stb  = 1'b0;
    bus.rw   = 1'b0;
    bus.addr = '0;
    bus.dtw  = '0;
    test_reset;
    test_out_dir;
    test_led_mask;
    test_edge_irq;
    test_w1c_collision;
    test_unmapped;
    test_reset_mid;
    test_in;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
